// File: rtl/qbus_dma_arb.sv
// QBUS DMA arbiter: collects on-chip master requests and runs the vm2 DMR/DMGO/SACK handshake.
// Optional round-robin search start enabled by defining QBUS_ARB_RR_EN (default: fixed priority, req[0] highest).
module qbus_dma_arb #(
  parameter int NREQ = 4,
  parameter int TMO  = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            dmr_n,
  output logic            sack_n,
  input  logic            dmgo_n,
  input  logic            sync_n,
  input  logic            rply_n,
  output logic            busy,
  output logic            tmo_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OWN, S_REL} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   w_q, w_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            dmr_n_q, dmr_n_d;
  logic            sack_n_q, sack_n_d;
  logic            tmo_err_q, tmo_err_d;
  logic [1:0]      dmgo_sync_q, dmgo_sync_d;
  logic [1:0]      sync_sync_q, sync_sync_d;
  logic [1:0]      rply_sync_q, rply_sync_d;

  logic            dmgo_seen, bus_idle_seen, req_w;
  logic [IW-1:0]   base, win_idx;
  logic            win_found;

`ifdef QBUS_ARB_RR_EN
  logic [IW-1:0]   ptr_q, ptr_d;
  assign base = ptr_q;
`else
  assign base = '0;
`endif

  assign dmgo_seen     = ~dmgo_sync_q[1];
  assign bus_idle_seen = sync_sync_q[1] & rply_sync_q[1];
  assign req_w         = req[w_q];

  assign dmgo_sync_d = {dmgo_sync_q[0], dmgo_n};
  assign sync_sync_d = {sync_sync_q[0], sync_n};
  assign rply_sync_d = {rply_sync_q[0], rply_n};

  // First requester at or after the search base, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req[(int'(base) + i) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(base) + i) % NREQ);
      end
    end
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    w_d       = w_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    dmr_n_d   = dmr_n_q;
    sack_n_d  = sack_n_q;
    tmo_err_d = 1'b0;
`ifdef QBUS_ARB_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_REQ;
          w_d     = win_idx;
          cnt_d   = '0;
          dmr_n_d = 1'b0;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        // Once DMGO is seen the handshake must complete; an idle bus grants without a WAIT clock.
        if (dmgo_seen) begin
          if (!req_w) begin
            state_d  = S_REL;
            sack_n_d = 1'b0;
            dmr_n_d  = 1'b1;
          end else if (bus_idle_seen) begin
            state_d  = S_OWN;
            sack_n_d = 1'b0;
            dmr_n_d  = 1'b1;
            gnt_d    = NREQ'(1) << w_q;
          end else begin
            state_d = S_WAIT;
          end
        end else if (!req_w) begin
          state_d = S_IDLE;
          dmr_n_d = 1'b1;
        end else if (TMO != 0 && cnt_d == 8'(TMO)) begin
          state_d   = S_IDLE;
          dmr_n_d   = 1'b1;
          tmo_err_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (!req_w) begin
          state_d  = S_REL;
          sack_n_d = 1'b0;
          dmr_n_d  = 1'b1;
        end else if (bus_idle_seen) begin
          state_d  = S_OWN;
          sack_n_d = 1'b0;
          dmr_n_d  = 1'b1;
          gnt_d    = NREQ'(1) << w_q;
        end
      end
      S_OWN: begin
        if (!req_w) begin
          state_d = S_REL;
          gnt_d   = '0;
`ifdef QBUS_ARB_RR_EN
          ptr_d   = (w_q == IW'(NREQ - 1)) ? '0 : w_q + 1'b1;
`endif
        end
      end
      S_REL: begin
        state_d  = S_IDLE;
        sack_n_d = 1'b1;
      end
      default: begin
        state_d  = S_IDLE;
        gnt_d    = '0;
        dmr_n_d  = 1'b1;
        sack_n_d = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      dmr_n_q     <= 1'b1;
      sack_n_q    <= 1'b1;
      tmo_err_q   <= 1'b0;
      dmgo_sync_q <= 2'b11;
      sync_sync_q <= 2'b11;
      rply_sync_q <= 2'b11;
`ifdef QBUS_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      dmr_n_q     <= dmr_n_d;
      sack_n_q    <= sack_n_d;
      tmo_err_q   <= tmo_err_d;
      dmgo_sync_q <= dmgo_sync_d;
      sync_sync_q <= sync_sync_d;
      rply_sync_q <= rply_sync_d;
`ifdef QBUS_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign dmr_n   = dmr_n_q;
  assign sack_n  = sack_n_q;
  assign tmo_err = tmo_err_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_qbus_dma_arb.sv
// Scenario bench for qbus_dma_arb: expected grants are queued at stimulus time and popped on grant.
module tb_qbus_dma_arb;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       dmr_n, sack_n, busy, tmo_err;
  logic       dmgo_n, sync_n, rply_n;

  int tests_run    = 0;
  int tests_failed = 0;
  int inv_viol     = 0;

  logic [3:0] sb_q[$];

  qbus_dma_arb #(.NREQ(4), .TMO(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .dmr_n   (dmr_n),
    .sack_n  (sack_n),
    .dmgo_n  (dmgo_n),
    .sync_n  (sync_n),
    .rply_n  (rply_n),
    .busy    (busy),
    .tmo_err (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake invariants watched on every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (dmr_n === 1'b0 && sack_n === 1'b0) inv_viol++;
      if ($countones(gnt) > 1) inv_viol++;
      if (gnt !== 4'b0000 && sack_n !== 1'b0) inv_viol++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_dmr_low(input string tag);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dmr_n === 1'b0) begin ok = 1; break; end
    end
    if (!ok) begin
      tests_run++; tests_failed++;
      $display("FAIL %s: dmr_n never went low, got %b want 0", tag, dmr_n);
    end
  endtask

  task automatic wait_gnt_and_pop(input string tag);
    bit ok = 0;
    logic [3:0] exp;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (gnt !== 4'b0000) begin ok = 1; break; end
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL %s: no grant within bound, got %b", tag, gnt);
    end else if (sb_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: unexpected grant %b with empty scoreboard", tag, gnt);
    end else begin
      exp = sb_q.pop_front();
      if (gnt !== exp) begin
        tests_failed++;
        $display("FAIL %s: gnt got %b want %b", tag, gnt, exp);
      end
    end
  endtask

  task automatic wait_sack_high(input string tag);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sack_n === 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin
      tests_run++; tests_failed++;
      $display("FAIL %s: sack_n never released, got %b want 1", tag, sack_n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; dmgo_n = 1'b1; sync_n = 1'b1; rply_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({gnt, dmr_n, sack_n, busy, tmo_err} !== {4'b0000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got gnt=%b dmr_n=%b sack_n=%b busy=%b tmo=%b want 0000 1 1 0 0",
               gnt, dmr_n, sack_n, busy, tmo_err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({gnt, dmr_n, sack_n, busy} !== {4'b0000, 1'b1, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_idle: got gnt=%b dmr_n=%b sack_n=%b busy=%b", gnt, dmr_n, sack_n, busy);
    end
  endtask

  task automatic test_contention();
    logic [3:0] order[4];
`ifdef QBUS_ARB_RR_EN
    order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
`else
    order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    dmgo_n = 1'b0;
    req = 4'b1011;
    for (int r = 0; r < 4; r++) begin
      sb_q.push_back(order[r]);
      wait_gnt_and_pop($sformatf("contention_round%0d", r));
      req = 4'b1011 & ~gnt;
      wait_sack_high("contention_release");
      req = 4'b1011;
    end
    req = '0;
    dmgo_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    req = 4'b0010;
    wait_dmr_low("single_dmr");
    repeat (5) @(negedge clk);
    dmgo_n = 1'b0;
    sb_q.push_back(4'b0010);
    repeat (2) @(negedge clk);
    tests_run++;
    if (gnt !== 4'b0000 || sack_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_early: got gnt=%b sack_n=%b want 0000 1", gnt, sack_n);
    end
    @(negedge clk);
    tests_run++;
    if (sack_n !== 1'b0 || dmr_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_grant_edge: got sack_n=%b dmr_n=%b want 0 1", sack_n, dmr_n);
    end
    tests_run++;
    if (sb_q.size() == 0 || gnt !== sb_q[0]) begin
      tests_failed++;
      $display("FAIL single_gnt: got %b want 0010", gnt);
    end
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    req = '0;
    @(negedge clk);
    tests_run++;
    if (gnt !== 4'b0000 || sack_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_rel: got gnt=%b sack_n=%b want 0000 0", gnt, sack_n);
    end
    @(negedge clk);
    tests_run++;
    if (sack_n !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_idle: got sack_n=%b busy=%b want 1 0", sack_n, busy);
    end
    dmgo_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_bus_busy();
    int early = 0;
    sync_n = 1'b0;
    req = 4'b0001;
    wait_dmr_low("busy_dmr");
    dmgo_n = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (gnt !== 4'b0000 || sack_n !== 1'b1) early++;
    end
    tests_run++;
    if (early != 0) begin
      tests_failed++;
      $display("FAIL busy_hold: grant during bus cycle on %0d clks, want 0", early);
    end
    sync_n = 1'b1;
    sb_q.push_back(4'b0001);
    repeat (2) @(negedge clk);
    tests_run++;
    if (gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL busy_early: got gnt=%b want 0000", gnt);
    end
    wait_gnt_and_pop("busy_gnt");
    req = '0;
    @(negedge clk);
    tests_run++;
    if (gnt !== 4'b0000 || sack_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_rel: got gnt=%b sack_n=%b want 0000 0", gnt, sack_n);
    end
    @(negedge clk);
    tests_run++;
    if (sack_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_sack_off: got sack_n=%b want 1", sack_n);
    end
    dmgo_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    int first = -1;
    req = 4'b0100;
    wait_dmr_low("tmo_dmr");
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (tmo_err === 1'b1) begin first = k; break; end
    end
    tests_run++;
    if (first != 16) begin
      tests_failed++;
      $display("FAIL tmo_cycle: pulse at clk %0d want 16", first);
    end
    tests_run++;
    if (dmr_n !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_state: got dmr_n=%b busy=%b want 1 0", dmr_n, busy);
    end
    req = '0;
    @(negedge clk);
    tests_run++;
    if (tmo_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_pulse_width: got tmo_err=%b want 0", tmo_err);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abandon();
    int sack_clks = 0;
    int gnt_clks  = 0;
    req = 4'b0001;
    wait_dmr_low("aband_req_dmr");
    repeat (2) @(negedge clk);
    req = '0;
    @(negedge clk);
    tests_run++;
    if (dmr_n !== 1'b1 || sack_n !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abandon_req: got dmr_n=%b sack_n=%b busy=%b want 1 1 0", dmr_n, sack_n, busy);
    end
    repeat (3) @(negedge clk);

    sync_n = 1'b0;
    dmgo_n = 1'b0;
    req = 4'b0001;
    wait_dmr_low("aband_wait_dmr");
    repeat (3) @(negedge clk);
    tests_run++;
    if (dmr_n !== 1'b0 || sack_n !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL abandon_in_wait: got dmr_n=%b sack_n=%b busy=%b want 0 1 1", dmr_n, sack_n, busy);
    end
    req = '0;
    repeat (6) begin
      @(negedge clk);
      if (sack_n === 1'b0) sack_clks++;
      if (gnt !== 4'b0000) gnt_clks++;
    end
    tests_run++;
    if (sack_clks != 1 || gnt_clks != 0) begin
      tests_failed++;
      $display("FAIL abandon_wait: sack clks %0d gnt clks %0d want 1 0", sack_clks, gnt_clks);
    end
    sync_n = 1'b1;
    dmgo_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_grant();
    dmgo_n = 1'b0;
    req = 4'b0010;
    sb_q.push_back(4'b0010);
    wait_gnt_and_pop("rst_pre_gnt");
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if (gnt !== 4'b0000 || sack_n !== 1'b1 || dmr_n !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got gnt=%b sack_n=%b dmr_n=%b busy=%b want 0000 1 1 0",
               gnt, sack_n, dmr_n, busy);
    end
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req = 4'b0100;
    sb_q.push_back(4'b0100);
    wait_gnt_and_pop("rst_resume_gnt");
    req = '0;
    wait_sack_high("rst_resume_rel");
    dmgo_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_bus_busy();
    test_timeout();
    test_abandon();
    test_reset_mid_grant();
    tests_run++;
    if (inv_viol != 0) begin
      tests_failed++;
      $display("FAIL invariants: %0d violations want 0", inv_viol);
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d expected grants never seen want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
